// File: rtl/bus_arb2_3s.sv
// bus_arb2_3s
//   Round-robin arbiter for two bus masters that share one 2:1 three-state mux.
//   It drives the mux select and the bus output enable. Between two owners it
//   inserts TURN_CYCLES bus-idle cycles (oe=0), so two drivers are never enabled
//   on the bus at the same time.
//
// Parameters
//   MAX_TENURE   max consecutive grant cycles per owner (BUS_ARB_TENURE_EN only), >=1
//   TURN_CYCLES  bus-idle cycles after every release, >=1
//   CW           counter width, must hold max(MAX_TENURE, TURN_CYCLES)
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   req    [1:0] level request per master, held for the whole transfer
//   gnt    [1:0] one-hot-or-zero grant
//   sel    mux select, index of the current or last owner
//   oe     bus output enable, equal to |gnt
//   busy   high whenever the arbiter is not IDLE
//
// Optional feature
//   BUS_ARB_TENURE_EN: when defined, the owner is forced to release after
//   MAX_TENURE consecutive grant cycles. When undefined, no tenure counter
//   is built.
module bus_arb2_3s #(
  parameter int MAX_TENURE  = 8,
  parameter int TURN_CYCLES = 1,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       oe,
  output logic       busy
);

  if (MAX_TENURE < 1 || TURN_CYCLES < 1) begin : g_bad_param
    $error("bus_arb2_3s: MAX_TENURE and TURN_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

  state_t        state;
  logic          last;      // index of the last owner to release; a tie goes to ~last
  logic [CW-1:0] turn_cnt;

  // Arbitration happens in IDLE and on the final TURN cycle only. Any req
  // change in the earlier TURN cycles is not seen.
  logic arb_now, arb_vld, arb_idx;
  always_comb begin
    arb_now = (state == IDLE) || (state == TURN && turn_cnt == TURN_LAST);
    arb_vld = |req;
    arb_idx = (req == 2'b11) ? ~last : req[1];
  end

  logic own_idx, rel;
  assign own_idx = (state == OWN1);

`ifdef BUS_ARB_TENURE_EN
  localparam logic [CW-1:0] TEN_LAST = CW'(MAX_TENURE - 1);
  // ten_cnt is 0 during the first grant cycle, so the owner is released after
  // the cycle in which ten_cnt reaches MAX_TENURE-1.
  logic [CW-1:0] ten_cnt;
  assign rel = !req[own_idx] || (ten_cnt >= TEN_LAST);
`else
  assign rel = !req[own_idx];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      sel      <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      last     <= 1'b1;
      turn_cnt <= '0;
`ifdef BUS_ARB_TENURE_EN
      ten_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE, TURN: begin
          if (arb_now) begin
            if (arb_vld) begin
              state   <= arb_idx ? OWN1 : OWN0;
              gnt     <= {arb_idx, ~arb_idx};
              sel     <= arb_idx;
              oe      <= 1'b1;
              busy    <= 1'b1;
`ifdef BUS_ARB_TENURE_EN
              ten_cnt <= '0;
`endif
            end else begin
              // The bus stays parked. sel keeps the last owner.
              state <= IDLE;
              gnt   <= 2'b00;
              oe    <= 1'b0;
              busy  <= 1'b0;
            end
          end else if (turn_cnt != '1) begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (rel) begin
            state    <= TURN;
            gnt      <= 2'b00;
            oe       <= 1'b0;
            last     <= own_idx;
            turn_cnt <= '0;
          end
`ifdef BUS_ARB_TENURE_EN
          else if (ten_cnt != '1) begin
            ten_cnt <= ten_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          oe    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb2_3s.sv
// tb_bus_arb2_3s
//   Directed bench for bus_arb2_3s.
//   dut  : MAX_TENURE=4, TURN_CYCLES=1
//   dut3 : MAX_TENURE=4, TURN_CYCLES=3 (tests the turnaround length)
//   Each output sample is packed as {gnt, sel, oe, busy}.
module tb_bus_arb2_3s;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00, req3 = 2'b00;
  logic [1:0] gnt, gnt3;
  logic       sel, oe, busy, sel3, oe3, busy3;
  logic [4:0] obs, obs3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arb2_3s #(.MAX_TENURE(4), .TURN_CYCLES(1), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .oe(oe), .busy(busy)
  );

  bus_arb2_3s #(.MAX_TENURE(4), .TURN_CYCLES(3), .CW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .gnt(gnt3), .sel(sel3), .oe(oe3), .busy(busy3)
  );

  assign obs  = {gnt, sel, oe, busy};
  assign obs3 = {gnt3, sel3, oe3, busy3};

  // These checks run on every cycle for both instances: the grant is never
  // 11, oe matches |gnt, and ownership never passes from one master directly
  // to the other without an oe=0 cycle in between.
  logic [1:0] prev_g = 2'b00, prev_g3 = 2'b00;
  always @(negedge clk) begin
    checks++;
    if (gnt == 2'b11 || oe !== |gnt || (prev_g != 2'b00 && gnt != 2'b00 && gnt != prev_g)) begin
      errors++;
      $display("FAIL invariant dut: gnt=%b oe=%b prev_gnt=%b", gnt, oe, prev_g);
    end
    checks++;
    if (gnt3 == 2'b11 || oe3 !== |gnt3 || (prev_g3 != 2'b00 && gnt3 != 2'b00 && gnt3 != prev_g3)) begin
      errors++;
      $display("FAIL invariant dut3: gnt=%b oe=%b prev_gnt=%b", gnt3, oe3, prev_g3);
    end
    prev_g  <= gnt;
    prev_g3 <= gnt3;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset[%0d]: got %b want 00000", i, obs);
      end
    end
    rst_n = 1'b1;
    req   = 2'b00;
  endtask

  task automatic test_single;
    logic [1:0] r [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [4:0] e [5] = '{5'b01011, 5'b01011, 5'b01011, 5'b00001, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      req = r[i];
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL single[%0d]: got %b want %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] r [12] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11,
                           2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [4:0] e [12] = '{5'b01011, 5'b01011, 5'b00001, 5'b10111, 5'b00101, 5'b01011,
                           5'b00001, 5'b10111, 5'b00101, 5'b01011, 5'b00001, 5'b00000};
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      req = r[i];
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL round_robin[%0d]: got %b want %b", i, obs, e[i]);
      end
    end
  endtask

`ifdef BUS_ARB_TENURE_EN
  // Each owner holds the bus for 4 cycles, then 1 turnaround cycle follows,
  // so the pattern repeats every 5 cycles.
  task automatic test_tenure;
    logic [4:0] want;
    logic       own;
    pulse_reset();
    req = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      want = (i % 5 < 4) ? 5'b01011 : 5'b00001;
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL tenure_solo[%0d]: got %b want %b", i, obs, want);
      end
    end
    pulse_reset();
    req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      own  = ((i / 5) % 2) == 1;
      want = (i % 5 < 4) ? (own ? 5'b10111 : 5'b01011) : (own ? 5'b00101 : 5'b00001);
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL tenure_alt[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask
`else
  task automatic test_no_tenure;
    pulse_reset();
    req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== 5'b01011) begin
        errors++;
        $display("FAIL hold[%0d]: got %b want 01011", i, obs);
      end
    end
  endtask
`endif

  // Reset is applied while requester 1 owns the bus (sel=1). Before this,
  // last=0, so the tie seen after reset also shows that last was set back to 1.
  task automatic test_reset_mid;
    req = 2'b00;
    tick();
    tick();
    req = 2'b10;
    tick();
    checks++;
    if (obs !== 5'b10111) begin
      errors++;
      $display("FAIL mid_own1: got %b want 10111", obs);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset: got %b want 00000", obs);
    end
    rst_n = 1'b1;
    req   = 2'b11;
    tick();
    checks++;
    if (obs !== 5'b01011) begin
      errors++;
      $display("FAIL mid_after: got %b want 01011", obs);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  // dut3 holds TURN for three cycles. The req changes made in the first two
  // turnaround cycles must not be seen; the grant follows the req present on
  // the final turnaround cycle.
  task automatic test_turn_len;
    logic [1:0] r [9] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [4:0] e [9] = '{5'b01011, 5'b00001, 5'b00001, 5'b00001, 5'b10111,
                          5'b00101, 5'b00101, 5'b00101, 5'b00100};
    for (int i = 0; i < 9; i++) begin
      req3 = r[i];
      tick();
      checks++;
      if (obs3 !== e[i]) begin
        errors++;
        $display("FAIL turn_len[%0d]: got %b want %b", i, obs3, e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
`ifdef BUS_ARB_TENURE_EN
    test_tenure();
`else
    test_no_tenure();
`endif
    test_reset_mid();
    test_turn_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
